// File: rtl/cond_branch_ctrl_pkg.sv
// Shared types and helpers for the conditional-branch resolution sequencer.
// Optional statistics counters are enabled by defining COND_BRANCH_STATS_EN.
package cond_branch_pkg;

  typedef enum logic [1:0] {
    BR_CBZ   = 2'b00,
    BR_CBNZ  = 2'b01,
    BR_BCOND = 2'b10,
    BR_RSVD  = 2'b11
  } br_kind_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } ctrl_state_t;

  localparam int IMM_W = 19;
  localparam int REG_W = 64;

  // NZCV bit positions inside the flags word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Everything captured from execute except the PC, whose width is a parameter.
  typedef struct packed {
    br_kind_t         kind;
    cond_t            cond;
    logic [IMM_W-1:0] imm19;
    logic [REG_W-1:0] reg_val;
    logic [3:0]       flags;
  } branch_fields_t;

  // Word offset to byte offset: sign-extend to 64 bits, then scale by 4.
  function automatic logic [63:0] branch_offset(input logic [IMM_W-1:0] imm19);
    return {{(64 - IMM_W - 2){imm19[IMM_W-1]}}, imm19, 2'b00};
  endfunction

endpackage

// File: rtl/cond_branch_ctrl_if.sv
// Execute-side branch input, fetch-side redirect handshake and resolution outputs.
// master = execute/fetch environment, slave = cond_branch_ctrl.
interface cond_branch_ctrl_if #(
  parameter int ADDR_W = 64
) ();

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // The source holds valid and its payload stable until that edge; ready
  // may change freely and never depends combinationally on valid.
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] pc;
  logic [18:0]       imm19;
  logic [1:0]        br_kind;
  logic [3:0]        cond;
  logic [63:0]       reg_val;
  logic [3:0]        flags;

  logic              resolved_valid;
  logic              resolved_taken;

  logic              redirect_valid;
  logic              redirect_ready;
  logic [ADDR_W-1:0] redirect_target;

  logic              flush;

  modport master (
    output in_valid, pc, imm19, br_kind, cond, reg_val, flags, redirect_ready,
    input  in_ready, resolved_valid, resolved_taken, redirect_valid,
           redirect_target, flush
  );

  modport slave (
    input  in_valid, pc, imm19, br_kind, cond, reg_val, flags, redirect_ready,
    output in_ready, resolved_valid, resolved_taken, redirect_valid,
           redirect_target, flush
  );

endinterface

// File: rtl/cond_branch_ctrl_cond_code_eval.sv
// Combinational ARM condition-code evaluator: (cond, NZCV) -> taken.
module cond_code_eval
  import cond_branch_pkg::*;
(
  input  cond_t      cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !(c && !z);
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = !(!z && (n == v));
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_branch_ctrl.sv
// Conditional-branch resolution sequencer: IDLE -> EVAL -> (REDIRECT -> FLUSH) -> IDLE.
// Define COND_BRANCH_STATS_EN to add saturating taken/not-taken counters.
module cond_branch_ctrl
  import cond_branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int ADDR_W       = 64
) (
  input  logic              clk,
  input  logic              reset,
  cond_branch_ctrl_if.slave bus,
  output ctrl_state_t       dbg_state
`ifdef COND_BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_taken,
  output logic [31:0]       stat_not_taken
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LOAD =
    CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;

  logic [ADDR_W-1:0] pc_q;
  branch_fields_t    br_q;
  logic [ADDR_W-1:0] target_q;
  logic              resolved_valid_q;
  logic              resolved_taken_q;
  logic [CNT_W-1:0]  flush_cnt;

  logic              accept;
  logic              redirect_fire;
  logic              cond_taken;
  logic              eval_taken;
  logic [63:0]       offset;
  logic [ADDR_W-1:0] eval_target;

  assign accept        = (state == ST_IDLE) && bus.in_valid;
  assign redirect_fire = (state == ST_REDIRECT) && bus.redirect_ready;

  cond_code_eval u_cond_code_eval (
    .cond  (br_q.cond),
    .flags (br_q.flags),
    .taken (cond_taken)
  );

  // Target arithmetic wraps modulo 2^ADDR_W by construction.
  assign offset      = branch_offset(br_q.imm19);
  assign eval_target = pc_q + offset[ADDR_W-1:0];

  always_comb begin
    eval_taken = 1'b0;
    case (br_q.kind)
      BR_CBZ:   eval_taken = (br_q.reg_val == '0);
      BR_CBNZ:  eval_taken = (br_q.reg_val != '0);
      BR_BCOND: eval_taken = cond_taken;
      default:  eval_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        state_nxt = eval_taken ? ST_REDIRECT : ST_IDLE;
      end
      ST_REDIRECT: begin
        if (bus.redirect_ready) state_nxt = (FLUSH_CYCLES == 0) ? ST_IDLE : ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_cnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      br_q <= '0;
    end else if (accept) begin
      pc_q <= bus.pc;
      br_q <= '{kind:    br_kind_t'(bus.br_kind),
                cond:    cond_t'(bus.cond),
                imm19:   bus.imm19,
                reg_val: bus.reg_val,
                flags:   bus.flags};
    end
  end

  // Resolution is registered on the EVAL closing edge so that a taken
  // branch shows resolved_valid together with its first redirect_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_q         <= '0;
      resolved_valid_q <= 1'b0;
      resolved_taken_q <= 1'b0;
    end else begin
      resolved_valid_q <= (state == ST_EVAL);
      resolved_taken_q <= (state == ST_EVAL) && eval_taken;
      if (state == ST_EVAL) target_q <= eval_target;
    end
  end

  // Counter holds the number of flush cycles still to follow the current one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt <= '0;
    end else if (redirect_fire) begin
      flush_cnt <= FLUSH_LOAD;
    end else if ((state == ST_FLUSH) && (flush_cnt != '0)) begin
      flush_cnt <= flush_cnt - 1'b1;
    end
  end

`ifdef COND_BRANCH_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else if (state == ST_EVAL) begin
      if (eval_taken) begin
        if (stat_taken != '1) stat_taken <= stat_taken + 32'd1;
      end else begin
        if (stat_not_taken != '1) stat_not_taken <= stat_not_taken + 32'd1;
      end
    end
  end
`endif

  assign bus.in_ready        = (state == ST_IDLE);
  assign bus.resolved_valid  = resolved_valid_q;
  assign bus.resolved_taken  = resolved_taken_q;
  assign bus.redirect_valid  = (state == ST_REDIRECT);
  assign bus.redirect_target = target_q;
  assign bus.flush           = (state == ST_FLUSH);
  assign dbg_state           = state;

endmodule

// File: tb/tb_cond_branch_ctrl.sv
// Self-checking bench for cond_branch_ctrl: vector table, scoreboard and corner sequences.
module tb_cond_branch_ctrl;
  import cond_branch_pkg::*;

  localparam int FC = 2;

  logic clk;
  logic reset;
  ctrl_state_t dbg_state;
`ifdef COND_BRANCH_STATS_EN
  logic [31:0] stat_taken;
  logic [31:0] stat_not_taken;
  int          tb_taken;
  int          tb_not_taken;
`endif

  cond_branch_ctrl_if #(.ADDR_W(64)) bus ();

  cond_branch_ctrl #(.FLUSH_CYCLES(FC), .ADDR_W(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .dbg_state      (dbg_state)
`ifdef COND_BRANCH_STATS_EN
    ,
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [64:0] exp_q[$];
  logic [64:0] exp_e;
  logic        prev_rv = 1'b0;
  logic [63:0] prev_tgt = '0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.resolved_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resolve: got resolved_valid=1 expected no branch pending at %0t", $time);
        end else begin
          exp_e = exp_q.pop_front();
          check("resolved_taken", {64'd0, bus.resolved_taken}, {64'd0, exp_e[64]});
          if (exp_e[64]) begin
            check("redirect_target", {1'b0, bus.redirect_target}, {1'b0, exp_e[63:0]});
            check("redirect_with_resolve", {64'd0, bus.redirect_valid}, 65'd1);
`ifdef COND_BRANCH_STATS_EN
            tb_taken++;
`endif
          end else begin
            check("no_redirect", {64'd0, bus.redirect_valid}, 65'd0);
`ifdef COND_BRANCH_STATS_EN
            tb_not_taken++;
`endif
          end
        end
      end
      if (bus.redirect_valid && prev_rv)
        check("target_stable", {1'b0, bus.redirect_target}, {1'b0, prev_tgt});
      prev_rv  = bus.redirect_valid;
      prev_tgt = bus.redirect_target;
    end else begin
      prev_rv = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic fn, fz, fc, fv;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    case (c)
      4'h0: return fz;
      4'h1: return ~fz;
      4'h2: return fc;
      4'h3: return ~fc;
      4'h4: return fn;
      4'h5: return ~fn;
      4'h6: return fv;
      4'h7: return ~fv;
      4'h8: return fc & ~fz;
      4'h9: return ~fc | fz;
      4'hA: return ~(fn ^ fv);
      4'hB: return fn ^ fv;
      4'hC: return ~fz & ~(fn ^ fv);
      4'hD: return fz | (fn ^ fv);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] ref_target(input logic [63:0] p, input logic [18:0] im);
    longint off;
    off = longint'($signed(im)) * 4;
    return p + 64'(off);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got in_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic drive(input logic [1:0] k, input logic [3:0] c, input logic [63:0] rv,
                       input logic [3:0] f, input logic [63:0] p, input logic [18:0] im);
    bus.in_valid = 1'b1;
    bus.br_kind  = k;
    bus.cond     = c;
    bus.reg_val  = rv;
    bus.flags    = f;
    bus.pc       = p;
    bus.imm19    = im;
  endtask

  // Sends one branch with redirect_ready already high and follows it to IDLE.
  task automatic send_branch(input logic [1:0] k, input logic [3:0] c, input logic [63:0] rv,
                             input logic [3:0] f, input logic [63:0] p, input logic [18:0] im,
                             input logic et, input logic [63:0] etgt);
    int n;
    wait_idle();
    drive(k, c, rv, f, p, im);
    exp_q.push_back({et, etgt});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("accept_stall", {64'd0, bus.in_ready}, 65'd0);
    check("state_eval", {63'd0, dbg_state}, {63'd0, ST_EVAL});
    @(posedge clk); #1;
    check("resolved_pulse", {64'd0, bus.resolved_valid}, 65'd1);
    check("redirect_valid_lat2", {64'd0, bus.redirect_valid}, {64'd0, et});
    if (et) begin
      @(posedge clk); #1;
      n = 0;
      while (bus.flush && n < 8) begin
        n++;
        @(posedge clk); #1;
      end
      check("flush_len", 65'(n), 65'(FC));
    end
    check("ready_after", {64'd0, bus.in_ready}, 65'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  cond;
    logic [63:0] rv;
    logic [3:0]  flags;
    logic [63:0] pc;
    logic [18:0] imm;
    logic        et;
    logic [63:0] etgt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  initial begin
    // flags = {N, Z, C, V}
    vecs[0]  = '{2'b00, 4'h0, 64'd0, 4'b0000, 64'h1000, 19'h00010, 1'b1, 64'h1040};
    vecs[1]  = '{2'b01, 4'h0, 64'd0, 4'b0000, 64'h1000, 19'h7FFFF, 1'b0, 64'h0};
    vecs[2]  = '{2'b01, 4'h0, 64'd5, 4'b0000, 64'h1000, 19'h7FFFF, 1'b1, 64'hFFC};
    vecs[3]  = '{2'b00, 4'h0, 64'd5, 4'b0000, 64'h1000, 19'h00010, 1'b0, 64'h0};
    vecs[4]  = '{2'b10, 4'hA, 64'd0, 4'b1001, 64'h2000, 19'h00004, 1'b1, 64'h2010};
    vecs[5]  = '{2'b10, 4'hA, 64'd0, 4'b1000, 64'h2000, 19'h00004, 1'b0, 64'h0};
    vecs[6]  = '{2'b10, 4'hD, 64'd0, 4'b0100, 64'h2000, 19'h00008, 1'b1, 64'h2020};
    vecs[7]  = '{2'b10, 4'hF, 64'd0, 4'b0000, 64'h2000, 19'h00001, 1'b1, 64'h2004};
    vecs[8]  = '{2'b10, 4'hE, 64'd0, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFC, 19'h00001, 1'b1, 64'h0};
    vecs[9]  = '{2'b10, 4'hE, 64'd0, 4'b0000, 64'h0100_0000, 19'h40000, 1'b1, 64'h00F0_0000};
    vecs[10] = '{2'b11, 4'hE, 64'd0, 4'b0000, 64'h3000, 19'h00010, 1'b0, 64'h0};
    vecs[11] = '{2'b10, 4'h0, 64'd0, 4'b0000, 64'h3000, 19'h00010, 1'b0, 64'h0};
    vecs[12] = '{2'b10, 4'h8, 64'd0, 4'b0010, 64'h3000, 19'h00010, 1'b1, 64'h3040};
    vecs[13] = '{2'b10, 4'h9, 64'd0, 4'b0010, 64'h3000, 19'h00010, 1'b0, 64'h0};
    vecs[14] = '{2'b10, 4'h6, 64'd0, 4'b0001, 64'h4000, 19'h7FFFE, 1'b1, 64'h3FF8};
    vecs[15] = '{2'b10, 4'h4, 64'd0, 4'b0000, 64'h4000, 19'h00002, 1'b0, 64'h0};
    vecs[16] = '{2'b10, 4'hC, 64'd0, 4'b0000, 64'h4000, 19'h00002, 1'b1, 64'h4008};
    vecs[17] = '{2'b10, 4'hB, 64'd0, 4'b1000, 64'h4000, 19'h00003, 1'b1, 64'h400C};
    vecs[18] = '{2'b10, 4'h3, 64'd0, 4'b0010, 64'h4000, 19'h00003, 1'b0, 64'h0};
    vecs[19] = '{2'b10, 4'h5, 64'd0, 4'b0000, 64'h5000, 19'h00100, 1'b1, 64'h5400};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [63:0] rp;
    logic [18:0] rim;
    logic [3:0]  rc;
    logic [3:0]  rf;
    int          n;

    reset              = 1'b0;
    bus.in_valid       = 1'b0;
    bus.pc             = '0;
    bus.imm19          = '0;
    bus.br_kind        = '0;
    bus.cond           = '0;
    bus.reg_val        = '0;
    bus.flags          = '0;
    bus.redirect_ready = 1'b1;
`ifdef COND_BRANCH_STATS_EN
    tb_taken     = 0;
    tb_not_taken = 0;
`endif

    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready", {64'd0, bus.in_ready}, 65'd1);
    check("rst_resolved_valid", {64'd0, bus.resolved_valid}, 65'd0);
    check("rst_resolved_taken", {64'd0, bus.resolved_taken}, 65'd0);
    check("rst_redirect_valid", {64'd0, bus.redirect_valid}, 65'd0);
    check("rst_flush", {64'd0, bus.flush}, 65'd0);
    check("rst_target", {1'b0, bus.redirect_target}, 65'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++)
      send_branch(vecs[i].kind, vecs[i].cond, vecs[i].rv, vecs[i].flags,
                  vecs[i].pc, vecs[i].imm, vecs[i].et, vecs[i].etgt);

    // Back-to-back not-taken: second accept lands on the resolution cycle.
    drive(2'b01, 4'h0, 64'd0, 4'b0000, 64'h1000, 19'h7FFFF);
    exp_q.push_back({1'b0, 64'h0});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_ready", {64'd0, bus.in_ready}, 65'd1);
    drive(2'b00, 4'h0, 64'd7, 4'b0000, 64'h1000, 19'h00001);
    exp_q.push_back({1'b0, 64'h0});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b_accepted", {64'd0, bus.in_ready}, 65'd0);
    @(posedge clk); #1;
    check("b2b_ready2", {64'd0, bus.in_ready}, 65'd1);

    // Fetch stalls the redirect; in_valid pulses meanwhile must be ignored.
    bus.redirect_ready = 1'b0;
    drive(2'b00, 4'h0, 64'd0, 4'b0000, 64'h3000, 19'h00008);
    exp_q.push_back({1'b1, 64'h3020});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("hold_rv_first", {64'd0, bus.redirect_valid}, 65'd1);
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 4'h0, 64'd0, 4'b0000, 64'h9000, 19'h00001);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("hold_rv", {64'd0, bus.redirect_valid}, 65'd1);
      check("hold_target", {1'b0, bus.redirect_target}, {1'b0, 64'h3020});
      check("hold_in_ready", {64'd0, bus.in_ready}, 65'd0);
    end
    bus.redirect_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_rv_drop", {64'd0, bus.redirect_valid}, 65'd0);
    n = 0;
    while (bus.flush && n < 8) begin
      n++;
      @(posedge clk); #1;
    end
    check("hs_flush_len", 65'(n), 65'(FC));
    check("hs_ready", {64'd0, bus.in_ready}, 65'd1);

    // Random condition codes and offsets.
    for (int i = 0; i < 24; i++) begin
      rp  = {$urandom(), $urandom()};
      rim = 19'($urandom_range(0, 19'h7FFFF));
      rc  = 4'($urandom_range(0, 15));
      rf  = 4'($urandom_range(0, 15));
      send_branch(2'b10, rc, 64'd0, rf, rp, rim, ref_cond(rc, rf), ref_target(rp, rim));
    end

`ifdef COND_BRANCH_STATS_EN
    check("stat_taken", 65'(stat_taken), 65'(tb_taken));
    check("stat_not_taken", 65'(stat_not_taken), 65'(tb_not_taken));
`endif

    // Reset mid-FLUSH: outputs drop without a clock edge.
    drive(2'b00, 4'h0, 64'd0, 4'b0000, 64'h6000, 19'h00004);
    exp_q.push_back({1'b1, 64'h6010});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_flush_on", {64'd0, bus.flush}, 65'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_flush_async", {64'd0, bus.flush}, 65'd0);
    check("rst_flush_ready", {64'd0, bus.in_ready}, 65'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rel1_ready", {64'd0, bus.in_ready}, 65'd1);
    check("rel1_target", {1'b0, bus.redirect_target}, 65'd0);
`ifdef COND_BRANCH_STATS_EN
    check("rst_stat_taken", 65'(stat_taken), 65'd0);
    check("rst_stat_not_taken", 65'(stat_not_taken), 65'd0);
`endif
    @(posedge clk); #1;

    // Reset mid-REDIRECT while fetch is stalled.
    bus.redirect_ready = 1'b0;
    drive(2'b01, 4'h0, 64'd3, 4'b0000, 64'h7000, 19'h00004);
    exp_q.push_back({1'b1, 64'h7010});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_redirect_on", {64'd0, bus.redirect_valid}, 65'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_rv_async", {64'd0, bus.redirect_valid}, 65'd0);
    check("rst_rv_flush", {64'd0, bus.flush}, 65'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.redirect_ready = 1'b1;
    #1;
    check("rel2_ready", {64'd0, bus.in_ready}, 65'd1);
    check("rel2_rv", {64'd0, bus.redirect_valid}, 65'd0);
    @(posedge clk); #1;

    send_branch(2'b00, 4'h0, 64'd0, 4'b0000, 64'h8000, 19'h00002, 1'b1, 64'h8008);
    @(posedge clk); #1;

    check("queue_drained", 65'(exp_q.size()), 65'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
